// File: rtl/m_msx_dram_ctrl_if.sv
// m_msx_dram_ctrl_if: request/busy bus between a core stage and the DRAM model.
// The master drives requests; the slave returns read beats and write acks.
interface m_msx_dram_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  w_req;
  logic                  w_we;
  logic                  w_burst;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [DATA_W/8-1:0]   w_be;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_oe;
  logic                  r_ack;
  logic                  r_busy;

  modport master (
    output w_req, w_we, w_burst, w_addr, w_wdata, w_be,
    input  r_rdata, r_oe, r_ack, r_busy
  );

  modport slave (
    input  w_req, w_we, w_burst, w_addr, w_wdata, w_be,
    output r_rdata, r_oe, r_ack, r_busy
  );
endinterface

// File: rtl/m_msx_dram_ctrl.sv
// m_msx_dram_ctrl: multi-cycle DRAM model, fixed latency, byte-enabled writes.
// Define MSX_DRAM_BURST_EN to build wrapped (critical-word-first) burst reads.
module m_msx_dram_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2048,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 3,
  parameter int BURST_LEN = 4
) (
  input logic             w_clock,
  input logic             w_rst_n,
  m_msx_dram_ctrl_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              oe_q, oe_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              mem_we;
  logic [DATA_W-1:0] wmerge;
  logic              unused_in;

`ifdef MSX_DRAM_BURST_EN
  localparam int BL_W = $clog2(BURST_LEN);
  logic             burst_q, burst_d;
  logic [BL_W-1:0]  beat_q, beat_d;
  logic [IDX_W-1:0] beat_idx;
  assign beat_idx  = {idx_q[IDX_W-1:BL_W], idx_q[BL_W-1:0] + beat_q};
  assign unused_in = ^bus.w_addr;
`else
  assign unused_in = ^{bus.w_addr, bus.w_burst};
`endif

  assign bus.r_rdata = rdata_q;
  assign bus.r_oe    = oe_q;
  assign bus.r_ack   = ack_q;
  assign bus.r_busy  = busy_q;

  // Byte-merge write data over the addressed word.
  always_comb begin
    wmerge = mem[idx_q];
    for (int b = 0; b < BE_W; b++) begin
      if (be_q[b]) wmerge[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  // Next-state logic: accept, latency countdown, completion, burst beats.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    busy_d  = busy_q;
    rdata_d = '0;
    oe_d    = 1'b0;
    ack_d   = 1'b0;
    mem_we  = 1'b0;
`ifdef MSX_DRAM_BURST_EN
    burst_d = burst_q;
    beat_d  = beat_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.w_req && !busy_q) begin
          idx_d   = bus.w_addr[OFF_W +: IDX_W];
          we_d    = bus.w_we;
          wdata_d = bus.w_wdata;
          be_d    = bus.w_be;
`ifdef MSX_DRAM_BURST_EN
          burst_d = bus.w_burst;
`endif
          cnt_d   = 8'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (we_q) begin
          mem_we  = w_rst_n;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef MSX_DRAM_BURST_EN
        end else if (burst_q) begin
          oe_d    = 1'b1;
          rdata_d = mem[idx_q];
          beat_d  = BL_W'(1);
          state_d = XFER;
`endif
        end else begin
          oe_d    = 1'b1;
          rdata_d = mem[idx_q];
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
`ifdef MSX_DRAM_BURST_EN
      XFER: begin
        oe_d    = 1'b1;
        rdata_d = mem[beat_idx];
        if (beat_q == BL_W'(BURST_LEN - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge w_clock) begin
    if (!w_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MSX_DRAM_BURST_EN
      burst_q <= 1'b0;
      beat_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
`ifdef MSX_DRAM_BURST_EN
      burst_q <= burst_d;
      beat_q  <= beat_d;
`endif
    end
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge w_clock) begin
    if (mem_we) mem[idx_q] <= wmerge;
  end
endmodule
